// File: rtl/palette_lookup_arbiter.sv
// Round-robin arbiter sharing one combinational palette ROM among NUM_REQ pixel requesters.
// Latency: response registered two cycles after the grant; one lookup per cycle.
// Backpressure: rsp_valid & ~rsp_ready freezes every stage and suppresses grants.
module palette_lookup_arbiter #(
    parameter int         NUM_REQ         = 4,
    parameter int         ID_W            = $clog2(NUM_REQ),
    parameter logic [3:0] TRANSPARENT_IDX = 4'd0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [NUM_REQ*4-1:0] req_index,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [3:0]           pal_index,
    input  logic [3:0]           pal_red,
    input  logic [3:0]           pal_green,
    input  logic [3:0]           pal_blue,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [ID_W-1:0]      rsp_id,
    output logic [3:0]           rsp_red,
    output logic [3:0]           rsp_green,
    output logic [3:0]           rsp_blue,
    output logic                 rsp_transparent,
    output logic                 busy
);

    logic [ID_W-1:0] rr_ptr;
    logic            s1_valid;
    logic [ID_W-1:0] s1_id;
    logic [3:0]      s1_index;

    logic            adv;
    logic            any_req;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] next_ptr;
    logic [3:0]      win_index;

    assign adv = ~rsp_valid | rsp_ready;

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int              cand;
        logic [ID_W-1:0] cand_id;
        cand    = 0;
        cand_id = '0;
        winner  = '0;
        any_req = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_id = cand[ID_W-1:0];
            if (!any_req && req[cand_id]) begin
                any_req = 1'b1;
                winner  = cand_id;
            end
        end
    end

    assign next_ptr  = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    assign win_index = req_index[{winner, 2'b00} +: 4];

    always_comb begin
        gnt = '0;
        if (!reset && adv && any_req) begin
            gnt[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr          <= '0;
            s1_valid        <= 1'b0;
            s1_id           <= '0;
            s1_index        <= 4'd0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_red         <= 4'd0;
            rsp_green       <= 4'd0;
            rsp_blue        <= 4'd0;
            rsp_transparent <= 1'b0;
        end else if (adv) begin
            s1_valid <= any_req;
            if (any_req) begin
                s1_id    <= winner;
                s1_index <= win_index;
                rr_ptr   <= next_ptr;
            end
            rsp_valid       <= s1_valid;
            rsp_id          <= s1_id;
            rsp_red         <= pal_red;
            rsp_green       <= pal_green;
            rsp_blue        <= pal_blue;
            rsp_transparent <= (s1_index == TRANSPARENT_IDX);
        end
    end

    // The ROM address comes straight from the stage-1 register so it holds while stalled.
    assign pal_index = s1_index;
    assign busy      = s1_valid | rsp_valid;

endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// Bench for palette_lookup_arbiter: directed scenarios plus a randomized run against a queue/slot reference model.
module tb_palette_lookup_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] req = '0;
    logic [4*N-1:0] req_index = '0;
    logic [N-1:0] gnt;
    logic [3:0]   pal_index;
    logic [3:0]   pal_red, pal_green, pal_blue;
    logic         rsp_valid;
    logic         rsp_ready = 1'b1;
    logic [1:0]   rsp_id;
    logic [3:0]   rsp_red, rsp_green, rsp_blue;
    logic         rsp_transparent;
    logic         busy;

    logic [11:0]  rom [16];
    logic [11:0]  rsp_rgb;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign {pal_red, pal_green, pal_blue} = rom[pal_index];
    assign rsp_rgb = {rsp_red, rsp_green, rsp_blue};

    palette_lookup_arbiter #(.NUM_REQ(N)) dut (
        .clk(clk), .reset(reset), .req(req), .req_index(req_index), .gnt(gnt),
        .pal_index(pal_index), .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_red(rsp_red), .rsp_green(rsp_green), .rsp_blue(rsp_blue),
        .rsp_transparent(rsp_transparent), .busy(busy)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; req = '0; rsp_ready = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'hF; req_index = 16'h1234;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt got %b want 0000", gnt); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", busy); end
        n_cmp++; if (pal_index !== 4'd0) begin n_bad++; $display("FAIL reset_pal_index got %h want 0", pal_index); end
        n_cmp++; if ({rsp_id, rsp_rgb, rsp_transparent} !== 15'd0) begin n_bad++;
            $display("FAIL reset_rsp_fields got id=%0d rgb=%h tr=%b want zeros", rsp_id, rsp_rgb, rsp_transparent); end
        next_cycle();
        reset = 1'b0; req = '0;
    endtask

    task automatic test_single();
        req = 4'b0010; req_index = 16'h0020;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL single_gnt got %b want 0010", gnt); end
        next_cycle();
        req = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || pal_index !== 4'd2 || busy !== 1'b1) begin n_bad++;
            $display("FAIL single_s1 got v=%b pal=%h busy=%b want 0/2/1", rsp_valid, pal_index, busy); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_rgb !== 12'hC65 || rsp_transparent !== 1'b0) begin n_bad++;
            $display("FAIL single_rsp got v=%b id=%0d rgb=%h tr=%b want 1/1/C65/0", rsp_valid, rsp_id, rsp_rgb, rsp_transparent); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain got %b want 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [15:0] idx;
        do_reset();
        idx = 16'($urandom);
        req_index = idx;
        for (int c = 0; c < 8; c++) begin
            req = (c < 5) ? 4'hF : 4'h0;
            @(negedge clk);
            if (c < 5) begin
                n_cmp++; if (gnt !== 4'(1 << (c % 4))) begin n_bad++;
                    $display("FAIL rr_gnt c=%0d got %b want %b", c, gnt, 4'(1 << (c % 4))); end
            end
            if (c >= 2 && c < 7) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'((c - 2) % 4)
                             || rsp_rgb !== rom[idx[4*((c-2)%4) +: 4]]) begin n_bad++;
                    $display("FAIL rr_rsp c=%0d got v=%b id=%0d rgb=%h want 1/%0d/%h", c, rsp_valid, rsp_id, rsp_rgb,
                             (c - 2) % 4, rom[idx[4*((c-2)%4) +: 4]]); end
            end
            if (c == 7) begin
                n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain got %b want 0", rsp_valid); end
            end
            next_cycle();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        req_index = 16'h0028;
        req = 4'b0011;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL bp_gnt0 got %b want 0001", gnt); end
        next_cycle();
        req = 4'b0010;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL bp_gnt1 got %b want 0010", gnt); end
        next_cycle();
        req = 4'b0100; req_index = 16'h0328; rsp_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++; if (gnt !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_rgb !== 12'hA00
                         || pal_index !== 4'd2) begin n_bad++;
                $display("FAIL bp_hold c=%0d got g=%b v=%b id=%0d rgb=%h pal=%h want 0000/1/0/A00/2",
                         c, gnt, rsp_valid, rsp_id, rsp_rgb, pal_index); end
            next_cycle();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100 || rsp_valid !== 1'b1 || rsp_id !== 2'd0) begin n_bad++;
            $display("FAIL bp_resume got g=%b v=%b id=%0d want 0100/1/0", gnt, rsp_valid, rsp_id); end
        next_cycle();
        req = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_rgb !== 12'hC65) begin n_bad++;
            $display("FAIL bp_rsp1 got v=%b id=%0d rgb=%h want 1/1/C65", rsp_valid, rsp_id, rsp_rgb); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rgb !== rom[3]) begin n_bad++;
            $display("FAIL bp_rsp2 got v=%b id=%0d rgb=%h want 1/2/%h", rsp_valid, rsp_id, rsp_rgb, rom[3]); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_no_dup got %b want 0", rsp_valid); end
        next_cycle();
    endtask

    task automatic test_colour();
        do_reset();
        req = 4'b1000; req_index = 16'h0800;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b1000) begin n_bad++; $display("FAIL col_gnt3 got %b want 1000", gnt); end
        next_cycle();
        req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100) begin n_bad++; $display("FAIL col_gnt2 got %b want 0100", gnt); end
        next_cycle();
        req = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_rgb !== 12'hFFF || rsp_transparent !== 1'b1) begin n_bad++;
            $display("FAIL col_transp got v=%b id=%0d rgb=%h tr=%b want 1/3/FFF/1", rsp_valid, rsp_id, rsp_rgb, rsp_transparent); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rgb !== 12'hA00 || rsp_transparent !== 1'b0) begin n_bad++;
            $display("FAIL col_red got v=%b id=%0d rgb=%h tr=%b want 1/2/A00/0", rsp_valid, rsp_id, rsp_rgb, rsp_transparent); end
        next_cycle();
    endtask

    task automatic test_wrap();
        logic [3:0] exp [4];
        exp = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};
        req_index = 16'h5005;
        for (int c = 0; c < 4; c++) begin
            req = (c == 0) ? 4'b1000 : 4'b1001;
            @(negedge clk);
            n_cmp++; if (gnt !== exp[c]) begin n_bad++; $display("FAIL wrap_gnt c=%0d got %b want %b", c, gnt, exp[c]); end
            next_cycle();
        end
        req = '0;
        next_cycle();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        req = 4'b0001; req_index = 16'h0007;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0001) begin n_bad++; $display("FAIL rmid_gnt got %b want 0001", gnt); end
        next_cycle();
        reset = 1'b1; req = '0;
        next_cycle();
        reset = 1'b0; req = 4'b0110; req_index = 16'h0820;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || pal_index !== 4'd0) begin n_bad++;
            $display("FAIL rmid_flush got v=%b busy=%b pal=%h want 0/0/0", rsp_valid, busy, pal_index); end
        n_cmp++; if (gnt !== 4'b0010) begin n_bad++; $display("FAIL rmid_first_gnt got %b want 0010", gnt); end
        next_cycle();
        req = 4'b0100;
        @(negedge clk);
        n_cmp++; if (gnt !== 4'b0100 || rsp_valid !== 1'b0) begin n_bad++;
            $display("FAIL rmid_aborted got g=%b v=%b want 0100/0", gnt, rsp_valid); end
        next_cycle();
        req = '0;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_rgb !== 12'hC65) begin n_bad++;
            $display("FAIL rmid_rsp1 got v=%b id=%0d rgb=%h want 1/1/C65", rsp_valid, rsp_id, rsp_rgb); end
        next_cycle();
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_rgb !== 12'hA00) begin n_bad++;
            $display("FAIL rmid_rsp2 got v=%b id=%0d rgb=%h want 1/2/A00", rsp_valid, rsp_id, rsp_rgb); end
        next_cycle();
    endtask

    // Reference: pending requests per requester, a rotating priority pointer,
    // and a two-slot pipeline of expected (id, index) lookups that advances
    // whenever the output slot is empty or being accepted.
    task automatic test_random();
        bit         pending [N];
        logic [3:0] pidx [N];
        int         ptr, win, j;
        bit         s_v, r_v;
        int         s_id, r_id;
        logic [3:0] s_ix, r_ix;
        logic [N-1:0] exp_g;
        bit         m_adv;
        int         delivered;
        do_reset();
        ptr = 0; s_v = 0; r_v = 0; s_id = 0; r_id = 0; s_ix = 0; r_ix = 0; delivered = 0;
        for (int i = 0; i < N; i++) begin pending[i] = 0; pidx[i] = 0; end
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!pending[i] && ($urandom % 3 == 0)) begin
                    pending[i] = 1;
                    pidx[i] = 4'($urandom);
                end
                req[i] = pending[i];
                req_index[4*i +: 4] = pidx[i];
            end
            rsp_ready = ($urandom % 4 != 0);
            @(negedge clk);
            m_adv = !r_v || rsp_ready;
            win = -1;
            exp_g = '0;
            if (m_adv) begin
                for (int k = 0; k < N; k++) begin
                    j = (ptr + k) % N;
                    if (win < 0 && pending[j]) win = j;
                end
            end
            if (win >= 0) exp_g[win] = 1'b1;
            n_cmp++; if (gnt !== exp_g) begin n_bad++;
                $display("FAIL rand_gnt cyc=%0d got %b want %b", cyc, gnt, exp_g); end
            n_cmp++; if (rsp_valid !== r_v || busy !== (s_v | r_v) || pal_index !== s_ix) begin n_bad++;
                $display("FAIL rand_state cyc=%0d got v=%b busy=%b pal=%h want %b/%b/%h",
                         cyc, rsp_valid, busy, pal_index, r_v, s_v | r_v, s_ix); end
            if (r_v) begin
                n_cmp++; if (rsp_id !== 2'(r_id) || rsp_rgb !== rom[r_ix] || rsp_transparent !== (r_ix == 4'd0)) begin n_bad++;
                    $display("FAIL rand_rsp cyc=%0d got id=%0d rgb=%h tr=%b want %0d/%h/%b",
                             cyc, rsp_id, rsp_rgb, rsp_transparent, r_id, rom[r_ix], r_ix == 4'd0); end
                if (rsp_ready) delivered++;
            end
            if (m_adv) begin
                r_v = s_v; r_id = s_id; r_ix = s_ix;
                s_v = (win >= 0);
                if (win >= 0) begin
                    s_id = win; s_ix = pidx[win];
                    ptr = (win + 1) % N;
                    pending[win] = 0;
                end
            end
            next_cycle();
        end
        n_cmp++; if (delivered < 50) begin n_bad++; $display("FAIL rand_throughput got %0d want >= 50", delivered); end
        req = '0; rsp_ready = 1'b1;
        next_cycle();
        next_cycle();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 12'(i * 12'h159 + 12'h2B7);
        rom[0] = 12'hFFF;
        rom[2] = 12'hC65;
        rom[8] = 12'hA00;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_colour();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
